smem_output_arbiter: RTL
========================

Name: smem_output_arbiter

Overview:
- Shares one 512-bit result write-out channel among NUM_PE SMEM result-buffer instances.
- Each instance raises output_request when its batch is done, then streams its mem groups while permitted.
- Grants one PE at a time, round-robin, and holds the grant until that PE signals finish.
- Funnels the PE's 512-bit lines through a skid FIFO to the host write path, and back-pressures the granted PE through its stall input.

Parameters:
NUM_PE, 4, number of result-buffer instances (1..16)
DATA_W, 512, line width
FIFO_DEPTH, 16, skid FIFO entries (power of 2, >= 8)
AFULL_MARGIN, 4, free entries reserved for PE pipeline in-flight lines (PE output latency is 3 cycles)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
batch_start  in  1  pulse; opens a new batch (clears served mask)
pe_request  in  NUM_PE  per-PE output_request
pe_permit  out  NUM_PE  per-PE output_permit, one-hot or zero
pe_stall  out  NUM_PE  per-PE stall; only the granted bit can assert
pe_data  in  NUM_PE*DATA_W  per-PE output_data; PE i occupies bits [i*DATA_W +: DATA_W]
pe_valid  in  NUM_PE  per-PE output_valid
pe_finish  in  NUM_PE  per-PE output_finish (level, sticky until PE reset)
out_data  out  DATA_W  FIFO head
out_valid  out  1  FIFO non-empty
out_ready  in  1  downstream accepts head when out_valid & out_ready
grant_id  out  4  index of current/last granted PE
batch_done  out  1  level; all PEs served and FIFO drained
ovf_err  out  1  sticky; write attempted while FIFO full

Behaviour:
- Reset (async) clears all outputs and state: pe_permit=0, pe_stall=0, out_valid=0, out_data=0, grant_id=0, batch_done=0, ovf_err=0; served=0, rr_ptr=0, FIFO empty, state IDLE.
- FSM states: IDLE, GRANT, RELEASE, DONE.
- IDLE:
  - If served is all ones and the FIFO is empty -> DONE.
  - Otherwise pick the first i, searching from rr_ptr upward mod NUM_PE, with pe_request[i] & !served[i].
  - If found -> GRANT: grant_id=i, pe_permit[i]=1 from the next cycle.
  - If none is found, stay in IDLE.
- GRANT:
  - pe_permit[grant_id] stays high.
  - Each cycle with pe_valid[grant_id]=1 writes pe_data slice grant_id into the FIFO.
  - pe_valid from non-granted PEs is ignored.
  - pe_finish[grant_id]=1 -> RELEASE.
- RELEASE (one cycle):
  - Permit drops.
  - served[grant_id] is set.
  - rr_ptr = grant_id+1 wrapped at NUM_PE.
  - -> IDLE.
  - Minimum of 2 cycles between consecutive grants.
- DONE: batch_done=1. batch_start -> clear served and batch_done, -> IDLE.
- batch_start in any other state is ignored.
- Back-pressure: pe_stall[grant_id] = (FIFO free entries <= AFULL_MARGIN), registered (1-cycle delay). Non-granted stall bits are 0.
- FIFO:
  - A write and a read may occur in the same cycle; occupancy is unchanged.
  - A write into an empty FIFO gives out_valid high the next cycle (1-cycle latency).
  - out_data is held stable while out_valid & !out_ready.
  - Write while full: data dropped, ovf_err set until reset.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
- pe_request deasserting while in GRANT does not revoke the grant; only finish ends it.
- A pe_finish already high at grant time (PE with empty batch) gives GRANT for exactly 1 cycle, then RELEASE.
- Reset mid-stream discards FIFO contents and drops all permits immediately (asynchronously).

Optional Feature:
SMEM_ARB_STATS_EN:
- When defined, adds outputs stat_lines (32 b), the count of FIFO writes since the last batch_start, and stat_stall_cycles (32 b), the count of cycles any pe_stall bit is high.
- Both counters saturate at all ones, clear on reset and on an accepted batch_start, and are readable in any state.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- NUM_PE=4, all request together, PE0..3 stream 3/5/1/0 lines then finish, out_ready=1 -> grants in order 0,1,2,3; 9 lines out in PE order; batch_done high after the last line drains.
- rr_ptr=2 after a batch, batch_start, PE1 and PE3 request -> PE3 granted first, then PE1.
- out_ready=0 for 40 cycles while PE0 streams 30 lines -> pe_stall[0] rises when occupancy reaches 12; no ovf_err; all 30 lines out in order once out_ready=1.
- Force 20 back-to-back pe_valid, ignoring stall, with out_ready=0 -> 16 stored, ovf_err=1 and sticky.
- reset_n low mid-GRANT with 5 lines queued -> permits, out_valid and batch_done drop immediately; FIFO empty after release.
- With SMEM_ARB_STATS_EN defined, scenario 1 -> stat_lines=9, stat_stall_cycles=0; batch_start clears both to 0.

Source files
------------

// File: rtl/smem_output_arbiter.sv
// smem_output_arbiter: shares one result write-out channel among NUM_PE SMEM
// result buffers. Round-robin grant held until the PE finishes, lines funnelled
// through a skid FIFO, granted PE back-pressured through pe_stall.
// Optional build macro: SMEM_ARB_STATS_EN adds stat_lines / stat_stall_cycles.
module smem_output_arbiter #(
   parameter int NUM_PE       = 4,
   parameter int DATA_W       = 512,
   parameter int FIFO_DEPTH   = 16,
   parameter int AFULL_MARGIN = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     batch_start,
   input  logic [NUM_PE-1:0]        pe_request,
   output logic [NUM_PE-1:0]        pe_permit,
   output logic [NUM_PE-1:0]        pe_stall,
   input  logic [NUM_PE*DATA_W-1:0] pe_data,
   input  logic [NUM_PE-1:0]        pe_valid,
   input  logic [NUM_PE-1:0]        pe_finish,
   output logic [DATA_W-1:0]        out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [3:0]               grant_id,
   output logic                     batch_done,
`ifdef SMEM_ARB_STATS_EN
   output logic [31:0]              stat_lines,
   output logic [31:0]              stat_stall_cycles,
`endif
   output logic                     ovf_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
   // Occupancy at which free entries drop to the in-flight reserve.
   localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(FIFO_DEPTH - AFULL_MARGIN);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE, DONE} state_t;

   state_t             state_q, state_d;
   logic [3:0]         grant_id_q, grant_id_d;
   logic [3:0]         rr_ptr_q, rr_ptr_d;
   logic [NUM_PE-1:0]  served_q, served_d;
   logic               stall_q, stall_d;
   logic               ovf_q, ovf_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic [DATA_W-1:0]  fifo_mem_q [FIFO_DEPTH];

   logic [NUM_PE-1:0]  gnt_mask;
   logic [NUM_PE-1:0]  cand;
   logic [DATA_W-1:0]  sel_data;
   logic               sel_valid;
   logic               sel_finish;
   logic               pick_found;
   logic [3:0]         pick_id;
   logic               fifo_empty;
   logic               fifo_full;
   logic               wr_req;
   logic               wr_en;
   logic               rd_en;

   // Decode the current grant into a one-hot mask and select that PE's lane.
   always_comb begin
      gnt_mask = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         if (grant_id_q == 4'(i)) begin
            gnt_mask[i] = 1'b1;
            sel_data    = pe_data[i*DATA_W +: DATA_W];
         end
      end
      sel_valid  = |(pe_valid & gnt_mask);
      sel_finish = |(pe_finish & gnt_mask);
   end

   // Round-robin pick: first unserved requester at or above rr_ptr, else wrap to the lowest.
   always_comb begin
      cand       = pe_request & ~served_q;
      pick_found = 1'b0;
      pick_id    = '0;
      for (int i = 0; i < NUM_PE; i++) begin
         if (!pick_found && cand[i] && (4'(i) >= rr_ptr_q)) begin
            pick_found = 1'b1;
            pick_id    = 4'(i);
         end
      end
      for (int i = 0; i < NUM_PE; i++) begin
         if (!pick_found && cand[i]) begin
            pick_found = 1'b1;
            pick_id    = 4'(i);
         end
      end
   end

   // Arbitration FSM next-state logic.
   always_comb begin
      state_d    = state_q;
      grant_id_d = grant_id_q;
      rr_ptr_d   = rr_ptr_q;
      served_d   = served_q;
      case (state_q)
         IDLE: begin
            if ((&served_q) && fifo_empty) begin
               state_d = DONE;
            end else if (pick_found) begin
               state_d    = GRANT;
               grant_id_d = pick_id;
            end
         end
         GRANT: begin
            // Only finish ends a grant; request dropping is ignored.
            if (sel_finish) state_d = RELEASE;
         end
         RELEASE: begin
            served_d = served_q | gnt_mask;
            rr_ptr_d = (grant_id_q == 4'(NUM_PE - 1)) ? 4'd0 : grant_id_q + 4'd1;
            state_d  = IDLE;
         end
         DONE: begin
            if (batch_start) begin
               served_d = '0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Skid FIFO pointer/occupancy update, overflow flag and almost-full stall.
   always_comb begin
      fifo_empty = (count_q == '0);
      fifo_full  = (count_q == FULL_CNT);
      wr_req     = (state_q == GRANT) && sel_valid;
      wr_en      = wr_req && !fifo_full;
      rd_en      = !fifo_empty && out_ready;
      wr_ptr_d   = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d   = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d    = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
      ovf_d      = ovf_q | (wr_req && fifo_full);
      stall_d    = (count_q >= AFULL_CNT);
   end

   // Control state with asynchronous reset; reset drops permits immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         grant_id_q <= '0;
         rr_ptr_q   <= '0;
         served_q   <= '0;
         stall_q    <= 1'b0;
         ovf_q      <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         rr_ptr_q   <= rr_ptr_d;
         served_q   <= served_d;
         stall_q    <= stall_d;
         ovf_q      <= ovf_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage; contents are qualified by the occupancy counter, so no reset.
   always_ff @(posedge clk) begin
      if (wr_en) fifo_mem_q[wr_ptr_q] <= sel_data;
   end

   assign pe_permit  = (state_q == GRANT) ? gnt_mask : '0;
   assign pe_stall   = ((state_q == GRANT) && stall_q) ? gnt_mask : '0;
   assign out_valid  = !fifo_empty;
   assign out_data   = fifo_empty ? '0 : fifo_mem_q[rd_ptr_q];
   assign grant_id   = grant_id_q;
   assign batch_done = (state_q == DONE);
   assign ovf_err    = ovf_q;

`ifdef SMEM_ARB_STATS_EN
   logic [31:0] stat_lines_q, stat_lines_d;
   logic [31:0] stat_stall_q, stat_stall_d;
   logic        batch_clear;

   // Saturating line and stall-cycle counters, cleared by an accepted batch_start.
   always_comb begin
      batch_clear  = (state_q == DONE) && batch_start;
      stat_lines_d = stat_lines_q;
      stat_stall_d = stat_stall_q;
      if (batch_clear) begin
         stat_lines_d = '0;
         stat_stall_d = '0;
      end else begin
         if (wr_en && (stat_lines_q != '1)) stat_lines_d = stat_lines_q + 32'd1;
         if ((|pe_stall) && (stat_stall_q != '1)) stat_stall_d = stat_stall_q + 32'd1;
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_lines_q <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_lines_q <= stat_lines_d;
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_lines        = stat_lines_q;
   assign stat_stall_cycles = stat_stall_q;
`endif

endmodule
